wb_snoop_responder: RTL and testbench
=====================================

Name: wb_snoop_responder

Overview:
Per-core snoop agent sitting directly downstream of the snoop arbiter's snoop interface. One instance per core; its outputs form that core's slice of snoop_ack_i / snoop_valid_dat_i / snooped_dat_i. On a snoop-read request it looks up the core's local data cache through a request/grant/done port and returns hit data or a miss. It holds its response stable until the arbiter withdraws the snoop.

Parameters:
dw, 32, data width
aw, 32, address width
TIMEOUT, 16, max cycles waiting for cache_lookup_done_i before forcing a miss response (>=1)
ONLY_DIRTY, 1, 1: report valid data only for dirty hits; 0: any hit

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
snoop_adr_i  in  aw  snoop address from arbiter
snoop_type_i  in  1  1=snoop read requested (level), 0=idle
snoop_ack_o  out  1  response valid, held until snoop_type_i falls
snoop_valid_dat_o  out  1  qualifies snooped_dat_o (positive poll)
snooped_dat_o  out  dw  snooped data
cache_lookup_req_o  out  1  lookup request to local cache
cache_lookup_adr_o  out  aw  lookup address (latched snoop address)
cache_lookup_gnt_i  in  1  cache accepted the request this cycle
cache_lookup_done_i  in  1  one-cycle pulse: lookup result valid
cache_hit_i  in  1  tag hit, valid with done
cache_dirty_i  in  1  line dirty, valid with done
cache_dat_i  in  dw  word at address, valid with done

Behaviour:
- All outputs registered. Reset (async, any state): state=IDLE, all outputs 0, timeout counter 0, address register 0.
- States: IDLE, REQ, WAIT, RESP, DRAIN.
- IDLE: snoop_type_i=1 at edge -> latch snoop_adr_i into adr register, cache_lookup_req_o=1, go REQ. Address sampled once; later changes of snoop_adr_i ignored for this snoop.
- REQ: req held high until cache_lookup_gnt_i=1 sampled; then req=0, counter cleared, go WAIT. snoop_type_i=0 while in REQ -> req=0, IDLE (no ack). Gnt and type-fall same cycle -> DRAIN (request was accepted).
- REQ has no timeout; grant wait is unbounded.
- WAIT: counter increments each cycle. cache_lookup_done_i=1 -> go RESP, snoop_ack_o=1, snoop_valid_dat_o = cache_hit_i & (cache_dirty_i | ~ONLY_DIRTY), snooped_dat_o = cache_dat_i if valid else 0.
- WAIT timeout: counter reaches TIMEOUT-1 with no done -> RESP with ack=1, valid=0, data=0; done arriving later is ignored. Done on same cycle as timeout: done wins.
- snoop_type_i=0 in WAIT -> DRAIN (no ack).
- Latency: type rise to ack = 3 cycles minimum (grant and done each 1 cycle after request/grant).
- RESP: ack/valid/data held constant while snoop_type_i=1; type=0 -> all outputs 0, IDLE next cycle. Earliest new snoop is accepted from IDLE one cycle later.
- DRAIN: outputs 0; wait for cache_lookup_done_i (or timeout counter expiry), then IDLE. Result discarded.
- Counter width clog2(TIMEOUT+1); saturates, never wraps.
- cache_lookup_adr_o always equals the adr register.
- Never assert snoop_valid_dat_o without snoop_ack_o.

Test Plan:
- Dirty hit: type=1, adr=0x0000_1040; gnt next cycle; done+hit+dirty, dat=0xDEADBEEF 1 cycle later -> ack=1, valid=1, dat=0xDEADBEEF held until type=0; then all 0 the next cycle.
- Miss: done with hit=0 -> ack=1, valid=0, dat=0; clean hit with ONLY_DIRTY=1 -> valid=0; with ONLY_DIRTY=0 -> valid=1, data passed.
- Grant stall: gnt low 5 cycles -> req held high 5+ cycles with cache_lookup_adr_o=0x0000_1040, no ack; ack 2 cycles after gnt.
- Timeout: TIMEOUT=4, no done -> ack=1, valid=0 exactly 4 cycles after entering WAIT; late done ignored.
- Abort: type falls in WAIT -> no ack; done 3 cycles later -> return to IDLE; new snoop (adr=0x2000) then serviced with correct address.
- Async reset asserted mid-RESP between clock edges -> ack/valid/data/req drop to 0 immediately; after release, IDLE accepts a new snoop.

Source files
------------

// File: rtl/wb_snoop_responder.sv
// Per-core snoop agent: on a snoop read, looks up the local data cache and
// returns hit data or a miss, holding the response until the snoop is withdrawn.
module wb_snoop_responder #(
    parameter int dw         = 32,
    parameter int aw         = 32,
    parameter int TIMEOUT    = 16,
    parameter int ONLY_DIRTY = 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [aw-1:0] snoop_adr_i,
    input  logic          snoop_type_i,
    output logic          snoop_ack_o,
    output logic          snoop_valid_dat_o,
    output logic [dw-1:0] snooped_dat_o,
    output logic          cache_lookup_req_o,
    output logic [aw-1:0] cache_lookup_adr_o,
    input  logic          cache_lookup_gnt_i,
    input  logic          cache_lookup_done_i,
    input  logic          cache_hit_i,
    input  logic          cache_dirty_i,
    input  logic [dw-1:0] cache_dat_i
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    state_t        state_q;
    logic [aw-1:0] adr_q;
    logic          req_q;
    logic          ack_q;
    logic          vld_q;
    logic [dw-1:0] dat_q;
    logic [CW-1:0] cnt_q;

    logic          only_dirty;
    logic          expired;
    logic          hit_ok;
    logic [CW-1:0] cnt_inc;

    assign only_dirty = (ONLY_DIRTY != 0);
    assign expired    = (cnt_q == CW'(TIMEOUT - 1));
    assign hit_ok     = cache_hit_i & (cache_dirty_i | ~only_dirty);
    assign cnt_inc    = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            vld_q   <= 1'b0;
            dat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (snoop_type_i) begin
                        adr_q   <= snoop_adr_i;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (cache_lookup_gnt_i) begin
                        // Once granted the cache owes us a done, so an aborted
                        // snoop still has to drain it.
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= snoop_type_i ? WAIT : DRAIN;
                    end else if (!snoop_type_i) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (!snoop_type_i) begin
                        // A done/expiry coinciding with the abort is already the
                        // drain condition, so skip DRAIN rather than wait forever.
                        cnt_q   <= cnt_inc;
                        state_q <= (cache_lookup_done_i || expired) ? IDLE : DRAIN;
                    end else if (cache_lookup_done_i) begin
                        ack_q   <= 1'b1;
                        vld_q   <= hit_ok;
                        dat_q   <= hit_ok ? cache_dat_i : '0;
                        state_q <= RESP;
                    end else if (expired) begin
                        ack_q   <= 1'b1;
                        vld_q   <= 1'b0;
                        dat_q   <= '0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                RESP: begin
                    if (!snoop_type_i) begin
                        ack_q   <= 1'b0;
                        vld_q   <= 1'b0;
                        dat_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    if (cache_lookup_done_i || expired) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    ack_q   <= 1'b0;
                    vld_q   <= 1'b0;
                    dat_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign snoop_ack_o        = ack_q;
    assign snoop_valid_dat_o  = vld_q;
    assign snooped_dat_o      = dat_q;
    assign cache_lookup_req_o = req_q;
    assign cache_lookup_adr_o = adr_q;

endmodule

// File: tb/tb_wb_snoop_responder.sv
// Directed bench: two responders (dirty-only/long timeout and any-hit/short
// timeout) share one stimulus stream and are checked against fixed expectations.
module tb_wb_snoop_responder;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic        typ;
    logic        gnt;
    logic        done;
    logic        hit;
    logic        dirty;
    logic [31:0] cdat;

    logic        a_ack, a_vld, a_req;
    logic [31:0] a_dat, a_adr;
    logic        b_ack, b_vld, b_req;
    logic [31:0] b_dat, b_adr;

    int unsigned total = 0;
    int unsigned bad   = 0;

    wb_snoop_responder #(.dw(32), .aw(32), .TIMEOUT(16), .ONLY_DIRTY(1)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .snoop_adr_i(adr), .snoop_type_i(typ),
        .snoop_ack_o(a_ack), .snoop_valid_dat_o(a_vld), .snooped_dat_o(a_dat),
        .cache_lookup_req_o(a_req), .cache_lookup_adr_o(a_adr),
        .cache_lookup_gnt_i(gnt), .cache_lookup_done_i(done),
        .cache_hit_i(hit), .cache_dirty_i(dirty), .cache_dat_i(cdat)
    );

    wb_snoop_responder #(.dw(32), .aw(32), .TIMEOUT(4), .ONLY_DIRTY(0)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .snoop_adr_i(adr), .snoop_type_i(typ),
        .snoop_ack_o(b_ack), .snoop_valid_dat_o(b_vld), .snooped_dat_o(b_dat),
        .cache_lookup_req_o(b_req), .cache_lookup_adr_o(b_adr),
        .cache_lookup_gnt_i(gnt), .cache_lookup_done_i(done),
        .cache_hit_i(hit), .cache_dirty_i(dirty), .cache_dat_i(cdat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic ack, input logic vld, input logic [31:0] dat);
        chk({tag, ".a_ack"}, 64'(a_ack), 64'(ack));
        chk({tag, ".a_vld"}, 64'(a_vld), 64'(vld));
        chk({tag, ".a_dat"}, 64'(a_dat), 64'(dat));
    endtask

    task automatic chk_b(input string tag, input logic ack, input logic vld, input logic [31:0] dat);
        chk({tag, ".b_ack"}, 64'(b_ack), 64'(ack));
        chk({tag, ".b_vld"}, 64'(b_vld), 64'(vld));
        chk({tag, ".b_dat"}, 64'(b_dat), 64'(dat));
    endtask

    task automatic cache_idle();
        done  = 1'b0;
        hit   = 1'b0;
        dirty = 1'b0;
        cdat  = '0;
    endtask

    task automatic cache_done(input logic h, input logic d, input logic [31:0] v);
        done  = 1'b1;
        hit   = h;
        dirty = d;
        cdat  = v;
    endtask

    initial begin
        rst = 1'b1;
        adr = '0;
        typ = 1'b0;
        gnt = 1'b0;
        cache_idle();
        repeat (2) @(posedge clk);
        #1;
        chk_a("rst", 1'b0, 1'b0, 32'h0);
        chk("rst.a_req", 64'(a_req), 64'h0);
        chk("rst.a_adr", 64'(a_adr), 64'h0);
        rst = 1'b0;
        tick();

        // Dirty hit, minimum latency, address sampled once
        typ = 1'b1;
        adr = 32'h0000_1040;
        tick();
        chk("dh.req", 64'(a_req), 64'h1);
        chk("dh.adr", 64'(a_adr), 64'h0000_1040);
        chk("dh.noack", 64'(a_ack), 64'h0);
        adr = 32'hFFFF_0000;
        gnt = 1'b1;
        tick();
        chk("dh.req_drop", 64'(a_req), 64'h0);
        chk("dh.wait_noack", 64'(a_ack), 64'h0);
        gnt = 1'b0;
        cache_done(1'b1, 1'b1, 32'hDEAD_BEEF);
        tick();
        chk_a("dh.resp", 1'b1, 1'b1, 32'hDEAD_BEEF);
        chk_b("dh.resp", 1'b1, 1'b1, 32'hDEAD_BEEF);
        cache_idle();
        tick();
        tick();
        chk_a("dh.hold", 1'b1, 1'b1, 32'hDEAD_BEEF);
        chk("dh.adr_hold", 64'(a_adr), 64'h0000_1040);
        typ = 1'b0;
        tick();
        chk_a("dh.release", 1'b0, 1'b0, 32'h0);

        // Miss
        typ = 1'b1;
        adr = 32'h0000_3000;
        tick();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        cache_done(1'b0, 1'b1, 32'h1234_5678);
        tick();
        chk_a("miss", 1'b1, 1'b0, 32'h0);
        chk_b("miss", 1'b1, 1'b0, 32'h0);
        cache_idle();
        typ = 1'b0;
        tick();

        // Clean hit: filtered by the dirty-only instance
        typ = 1'b1;
        tick();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        cache_done(1'b1, 1'b0, 32'hCAFE_F00D);
        tick();
        chk_a("clean", 1'b1, 1'b0, 32'h0);
        chk_b("clean", 1'b1, 1'b1, 32'hCAFE_F00D);
        cache_idle();
        typ = 1'b0;
        tick();

        // Grant stall
        typ = 1'b1;
        adr = 32'h0000_1040;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d.req", i), 64'(a_req), 64'h1);
            chk($sformatf("stall%0d.adr", i), 64'(a_adr), 64'h0000_1040);
            chk($sformatf("stall%0d.ack", i), 64'(a_ack), 64'h0);
            tick();
        end
        gnt = 1'b1;
        tick();
        chk("stall.req_drop", 64'(a_req), 64'h0);
        gnt = 1'b0;
        cache_done(1'b1, 1'b1, 32'h0000_55AA);
        tick();
        chk_a("stall.resp", 1'b1, 1'b1, 32'h0000_55AA);
        cache_idle();
        typ = 1'b0;
        tick();

        // Timeout on the TIMEOUT=4 instance; late done ignored there
        typ = 1'b1;
        adr = 32'h0000_4000;
        tick();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("tmo.early%0d", i), 64'(b_ack), 64'h0);
        end
        tick();
        chk_b("tmo.fire", 1'b1, 1'b0, 32'h0);
        chk("tmo.a_waiting", 64'(a_ack), 64'h0);
        cache_done(1'b1, 1'b1, 32'h0000_0099);
        tick();
        chk_b("tmo.late", 1'b1, 1'b0, 32'h0);
        chk_a("tmo.a_done", 1'b1, 1'b1, 32'h0000_0099);
        cache_idle();
        typ = 1'b0;
        tick();
        chk_b("tmo.release", 1'b0, 1'b0, 32'h0);

        // Abort in WAIT, drain the done, then a fresh snoop
        typ = 1'b1;
        adr = 32'h0000_5000;
        tick();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        typ = 1'b0;
        tick();
        chk_a("abort.noack", 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        chk("abort.drain_noack", 64'(a_ack), 64'h0);
        cache_done(1'b1, 1'b1, 32'h0000_0077);
        tick();
        chk_a("abort.discard", 1'b0, 1'b0, 32'h0);
        cache_idle();
        typ = 1'b1;
        adr = 32'h0000_2000;
        tick();
        chk("abort.new_req", 64'(a_req), 64'h1);
        chk("abort.new_adr", 64'(a_adr), 64'h0000_2000);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        cache_done(1'b1, 1'b1, 32'h0000_2222);
        tick();
        chk_a("abort.new_resp", 1'b1, 1'b1, 32'h0000_2222);
        cache_idle();
        typ = 1'b0;
        tick();

        // Asynchronous reset mid-RESP
        typ = 1'b1;
        adr = 32'h0000_6000;
        tick();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        cache_done(1'b1, 1'b1, 32'h0000_ABCD);
        tick();
        chk_a("arst.pre", 1'b1, 1'b1, 32'h0000_ABCD);
        cache_idle();
        #2;
        rst = 1'b1;
        #1;
        chk_a("arst.now", 1'b0, 1'b0, 32'h0);
        chk("arst.req", 64'(a_req), 64'h0);
        chk("arst.adr", 64'(a_adr), 64'h0);
        #1;
        rst = 1'b0;
        typ = 1'b0;
        tick();
        typ = 1'b1;
        adr = 32'h0000_7000;
        tick();
        chk("arst.new_req", 64'(a_req), 64'h1);
        chk("arst.new_adr", 64'(a_adr), 64'h0000_7000);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        cache_done(1'b0, 1'b0, 32'h0);
        tick();
        chk_a("arst.new_resp", 1'b1, 1'b0, 32'h0);
        cache_idle();
        typ = 1'b0;
        tick();
        chk_a("arst.final", 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
